mul8x6_seq_ctrl: RTL and testbench
==================================

# mul8x6_seq_ctrl

Sequencing controller that computes an unsigned 8-bit × 6-bit product by reusing a single combinational `Multiplier4x3` core over four clock cycles. It splits the operands into a 4-bit and a 3-bit digit grid, feeds one digit pair per cycle to the core, and shift-accumulates the partial products. It sits between a requester using a start/done handshake and the existing 4×3 multiplier datapath, so wider products need no wider multiplier.

## Interface
- Parameters: none. All widths are fixed by the 4×3 core: 8 = 2×4 and 6 = 2×3.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: request. Sampled only while `busy`=0.
- `a` in 8: multiplicand. Latched on an accepted `start`.
- `b` in 6: multiplier. Latched on an accepted `start`.
- `busy` out 1: high while an operation is in flight; `start` is ignored while it is high.
- `done` out 1: registered one-cycle pulse when `y` updates.
- `y` out 14: registered product; holds its value until the next completion.

## Operation
- Digits: aL=a[3:0], aH=a[7:4], bL=b[2:0], bH=b[5:3].
- Steps 0..3 feed the core with (aL,bL) shifted by 0, (aH,bL) shifted by 4, (aL,bH) shifted by 3, and (aH,bH) shifted by 7.
- Each partial product is at most 105 (7 bits). The maximum total is 255×63=16065, which is below 2^14, so the 14-bit accumulator never overflows and no saturation logic is required.
- FSM states:
  - IDLE: `busy`=0. On `start`=1: latch `a`/`b`, clear acc, step:=0, go to CALC.
  - CALC: `busy`=1. Each cycle acc += PP(step) << shift(step), then step++. When step==3, write acc+PP3 into `y`, set `done`:=1, and go to IDLE.
- A `start` during CALC is dropped. No queueing; the requester must re-assert it.
- A `start` in the cycle where `done`=1 is accepted, because the FSM is already in IDLE.
- Operands of 0 are not special-cased. They still take the full 4 steps, and `y`=0.
- Reset values: state=IDLE, `busy`=0, `done`=0, `y`=0, acc=0, step=0.
- Reset mid-operation: the operation is abandoned, no `done` is issued, and `y` returns to 0.

## Timing
- Let E0 be the edge that samples `start`. Steps are accumulated on E1..E4.
- `done` and the new `y` are visible after E4, which is a latency of 4 cycles. `done` drops after E5.
- `busy` is high in the cycles after E0 through E4, i.e. 4 cycles.
- Throughput is one result per 5 cycles with back-to-back `start`.
- `y` changes only on the completion edge. It is stable between completions, including during the next operation.
- The core is purely combinational. Critical path: step mux → Multiplier4x3 → constant shift → 14-bit adder → acc. There is no retiming.

## Structure
- Package `mul_seq_pkg` holds:
  - the state enum (IDLE, CALC);
  - the step width (2 bits);
  - shift constants SH0=0, SH1=4, SH2=3, SH3=7;
  - width constants A_W=8, B_W=6, Y_W=14.
- One sub-module, the existing `Multiplier4x3` (A[3:0], B[2:0] → Y[6:0]), is instantiated once. The digit muxes and the accumulator stay in this block.

## Test plan
- Reset, then idle:
  - Stimulus: hold `rst_n`=0 for 2 cycles, release.
  - Required: `busy`=0, `done`=0, `y`=0.
- Basic product:
  - Stimulus: `a`=5, `b`=3, `start` for one cycle.
  - Required: `done` pulses exactly 4 cycles later with `y`=15; `busy` is high for exactly 4 cycles.
- Extremes:
  - Stimulus: `a`=255, `b`=63.
  - Required: `y`=16065.
  - Stimulus: `a`=0, `b`=63.
  - Required: `y`=0 after the full 4 cycles.
- Back-to-back and drop:
  - Stimulus: `a`=200, `b`=45; pulse `start` again mid-CALC with `a`=1, `b`=1.
  - Required: the mid-CALC `start` is ignored; `y`=9000.
  - Stimulus: assert `start` with `a`=15, `b`=5 in the `done` cycle.
  - Required: the request is accepted; `y`=75 exactly 5 cycles after the first `done`.
- Hold:
  - Stimulus: after `y`=9000, start `a`=3, `b`=6.
  - Required: `y` stays 9000 until the completion edge, then becomes 18.
- Reset mid-op:
  - Stimulus: assert `rst_n`=0 at step 2 of `a`=255, `b`=63.
  - Required: no `done` pulse; `y`=0, `busy`=0; the next `start` completes normally.

Source files
------------

// File: rtl/mul8x6_seq_ctrl_pkg.sv
// Shared types and constants for the 8x6 sequential multiplier controller.
package mul_seq_pkg;

  typedef enum logic {
    IDLE,
    CALC
  } state_t;

  localparam int unsigned STEP_W = 2;
  localparam int unsigned A_W    = 8;
  localparam int unsigned B_W    = 6;
  localparam int unsigned Y_W    = 14;

  // Left-shift applied to the partial product of each step (aL.bL, aH.bL, aL.bH, aH.bH).
  localparam logic [2:0] SH0 = 3'd0;
  localparam logic [2:0] SH1 = 3'd4;
  localparam logic [2:0] SH2 = 3'd3;
  localparam logic [2:0] SH3 = 3'd7;

endpackage

// File: rtl/mul8x6_seq_ctrl_mult.sv
// Existing combinational 4x3 unsigned multiplier core.
module Multiplier4x3 (
  input  logic [3:0] A,
  input  logic [2:0] B,
  output logic [6:0] Y
);

  assign Y = {3'b000, A} * {4'b0000, B};

endmodule

// File: rtl/mul8x6_seq_ctrl.sv
// 8x6 unsigned multiply built from four passes through one 4x3 core,
// shift-accumulating one digit-pair partial product per clock.
module mul8x6_seq_ctrl
  import mul_seq_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic           busy,
  output logic           done,
  output logic [Y_W-1:0] y
);

  state_t              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [A_W-1:0]      a_q, a_d;
  logic [B_W-1:0]      b_q, b_d;
  logic [Y_W-1:0]      acc_q, acc_d;
  logic [Y_W-1:0]      y_q, y_d;
  logic                done_q, done_d;

  logic [3:0]          dig_a;
  logic [2:0]          dig_b;
  logic [2:0]          sh;
  logic [6:0]          pp;
  logic [Y_W-1:0]      pp_sh;

  always_comb begin
    dig_a = a_q[3:0];
    dig_b = b_q[2:0];
    sh    = SH0;
    case (step_q)
      2'd0: ;
      2'd1: begin
        dig_a = a_q[7:4];
        sh    = SH1;
      end
      2'd2: begin
        dig_b = b_q[5:3];
        sh    = SH2;
      end
      default: begin
        dig_a = a_q[7:4];
        dig_b = b_q[5:3];
        sh    = SH3;
      end
    endcase
  end

  Multiplier4x3 u_core (
    .A (dig_a),
    .B (dig_b),
    .Y (pp)
  );

  assign pp_sh = {{(Y_W-7){1'b0}}, pp} << sh;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    y_d     = y_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          step_d  = '0;
          state_d = CALC;
        end
      end
      default: begin
        acc_d  = acc_q + pp_sh;
        step_d = step_q + STEP_W'(1);
        // Last step writes the sum straight to y so completion costs no extra cycle.
        if (step_q == '1) begin
          y_d     = acc_q + pp_sh;
          done_d  = 1'b1;
          step_d  = '0;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      y_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == CALC);
  assign done = done_q;
  assign y    = y_q;

endmodule

// File: tb/tb_mul8x6_seq_ctrl.sv
// Scoreboard bench for mul8x6_seq_ctrl: stimulus pushes expected products,
// a negedge monitor pops and checks them whenever done is seen.
module tb_mul8x6_seq_ctrl;

  typedef struct {
    int unsigned y;
    int unsigned cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  a = '0;
  logic [5:0]  b = '0;
  logic        busy;
  logic        done;
  logic [13:0] y;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned cyc = 0;
  int unsigned model_y = 0;
  exp_t        sb[$];

  mul8x6_seq_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .y     (y)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int unsigned act, input int unsigned req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    #2;
  endtask

  // Present a request for one cycle; if it should be accepted, its result is
  // due 5 edges after the current edge count (E0 plus four steps).
  task automatic issue(input logic [7:0] av, input logic [5:0] bv,
                       input int unsigned yexp, input bit accept);
    exp_t e;
    a = av;
    b = bv;
    start = 1'b1;
    if (accept) begin
      e.y = yexp;
      e.cyc = cyc + 5;
      sb.push_back(e);
    end
    step_clk();
    start = 1'b0;
  endtask

  task automatic wait_done();
    int unsigned n = 0;
    while (!done && n < 20) begin
      step_clk();
      n++;
    end
    if (!done) chk("wait_done_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    while ((busy || done) && n < 20) begin
      step_clk();
      n++;
    end
    if (busy || done) chk("wait_idle_timeout", 0, 1);
    step_clk();
  endtask

  // Monitor: every done pops one expectation; otherwise y must hold.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (done) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("y_on_done", y, e.y);
            chk("done_latency", cyc, e.cyc);
            model_y = e.y;
          end
        end else begin
          chk("y_hold", y, model_y);
        end
      end
    end
  end

  initial begin
    // Reset, then idle
    rst_n = 1'b0;
    step_clk();
    step_clk();
    rst_n = 1'b1;
    step_clk();
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_y", y, 0);

    // Basic product with busy window: high after E0..E3, low after E4
    issue(8'd5, 6'd3, 15, 1'b1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step_clk();
      chk("busy_window", busy, (i < 4) ? 1 : 0);
    end
    wait_idle();

    // Extremes
    issue(8'd255, 6'd63, 16065, 1'b1);
    wait_idle();
    issue(8'd0, 6'd63, 0, 1'b1);
    wait_idle();

    // Mid-CALC start dropped, then a start in the done cycle is accepted
    issue(8'd200, 6'd45, 9000, 1'b1);
    step_clk();
    issue(8'd1, 6'd1, 1, 1'b0);
    chk("busy_during_drop", busy, 1);
    wait_done();
    issue(8'd15, 6'd5, 75, 1'b1);
    chk("busy_after_done_start", busy, 1);
    wait_idle();

    // Hold: y stays 9000 through the next operation, then becomes 18
    issue(8'd200, 6'd45, 9000, 1'b1);
    wait_idle();
    issue(8'd3, 6'd6, 18, 1'b1);
    wait_idle();
    chk("hold_final_y", y, 18);

    // Reset mid-operation at step 2
    issue(8'd255, 6'd63, 16065, 1'b1);
    step_clk();
    step_clk();
    rst_n = 1'b0;
    sb.delete();
    model_y = 0;
    step_clk();
    step_clk();
    rst_n = 1'b1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_y", y, 0);
    for (int i = 0; i < 6; i++) step_clk();

    issue(8'd7, 6'd9, 63, 1'b1);
    wait_idle();
    issue(8'd170, 6'd42, 7140, 1'b1);
    wait_idle();

    for (int i = 0; i < 4; i++) step_clk();
    chk("scoreboard_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
